// File: rtl/hsv2rgb_pipe.sv
// Four-stage HSV (h = hue/2) to RGB565 converter, one sample per clock, no backpressure.
// Define HSV2RGB_RGB888_EN to add the full-precision rgb888 output port and register.
module hsv2rgb_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  h,
  input  logic [7:0]  s,
  input  logic [7:0]  v,
  output logic        out_valid,
  output logic [15:0] rgb565
`ifdef HSV2RGB_RGB888_EN
  ,
  output logic [23:0] rgb888
`endif
);

  // x/255 via shift-and-add; exact for every multiple of 255.
  function automatic logic [7:0] div255(input logic [15:0] x);
    logic [16:0] sum;
    sum = 17'(x) + 17'(x >> 8) + 17'd1;
    return 8'(sum >> 8);
  endfunction

  logic       v1_q, v2_q, v3_q, out_valid_q;

  // Stage 1: hue wrap, sector and in-sector offset.
  logic [7:0] h_wrap, sec_base;
  logic [2:0] sec_d, sec1_q, sec2_q, sec3_q;
  logic [4:0] f_d, f1_q;
  logic [7:0] s1_q, v1d_q;

  always_comb begin
    h_wrap = (h >= 8'd180) ? h - 8'd180 : h;
    sec_d    = 3'd0;
    sec_base = 8'd0;
    if      (h_wrap >= 8'd150) begin sec_d = 3'd5; sec_base = 8'd150; end
    else if (h_wrap >= 8'd120) begin sec_d = 3'd4; sec_base = 8'd120; end
    else if (h_wrap >= 8'd90)  begin sec_d = 3'd3; sec_base = 8'd90;  end
    else if (h_wrap >= 8'd60)  begin sec_d = 3'd2; sec_base = 8'd60;  end
    else if (h_wrap >= 8'd30)  begin sec_d = 3'd1; sec_base = 8'd30;  end
    f_d = 5'(h_wrap - sec_base);
  end

  // Stage 2: kq ~= s*f/30; 273/8192 approximates 1/30 from below so kq never exceeds s.
  logic [21:0] kq_prod;
  logic [7:0]  kq_d, kq2_q, s2_q, v2d_q;

  always_comb begin
    kq_prod = 22'(s1_q) * 22'(f1_q) * 22'd273;
    kq_d    = 8'(kq_prod >> 13);
  end

  // Stage 3: unscaled p/q/t products.
  logic [7:0]  t_fac;
  logic [15:0] mp_d, mq_d, mt_d, mp3_q, mq3_q, mt3_q;
  logic [7:0]  v3d_q;

  always_comb begin
    t_fac = 8'd255 - s2_q + kq2_q;
    mp_d  = 16'(v2d_q) * 16'(8'd255 - s2_q);
    mq_d  = 16'(v2d_q) * 16'(8'd255 - kq2_q);
    mt_d  = 16'(v2d_q) * 16'(t_fac);
  end

  // Stage 4: normalise and route channels by sector.
  logic [7:0]  p_c, q_c, t_c, r_d, g_d, b_d;
  logic [15:0] rgb565_d, rgb565_q;

  always_comb begin
    p_c = div255(mp3_q);
    q_c = div255(mq3_q);
    t_c = div255(mt3_q);
    r_d = v3d_q; g_d = t_c; b_d = p_c;
    case (sec3_q)
      3'd1:    begin r_d = q_c;   g_d = v3d_q; b_d = p_c;   end
      3'd2:    begin r_d = p_c;   g_d = v3d_q; b_d = t_c;   end
      3'd3:    begin r_d = p_c;   g_d = q_c;   b_d = v3d_q; end
      3'd4:    begin r_d = t_c;   g_d = p_c;   b_d = v3d_q; end
      3'd5:    begin r_d = v3d_q; g_d = p_c;   b_d = q_c;   end
      default: begin r_d = v3d_q; g_d = t_c;   b_d = p_c;   end
    endcase
    rgb565_d = {5'(r_d >> 3), 6'(g_d >> 2), 5'(b_d >> 3)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
    end
  end

  // NOTE: datapath registers carry no reset; only valid bits and outputs must be clean after reset.
  always_ff @(posedge clk) begin
    sec1_q <= sec_d;   f1_q  <= f_d;   s1_q  <= s;     v1d_q <= v;
    sec2_q <= sec1_q;  kq2_q <= kq_d;  s2_q  <= s1_q;  v2d_q <= v1d_q;
    sec3_q <= sec2_q;  mp3_q <= mp_d;  mq3_q <= mq_d;  mt3_q <= mt_d;
    v3d_q  <= v2d_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rgb565_q <= '0;
    else if (v3_q) rgb565_q <= rgb565_d;
  end

`ifdef HSV2RGB_RGB888_EN
  logic [23:0] rgb888_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rgb888_q <= '0;
    else if (v3_q) rgb888_q <= {r_d, g_d, b_d};
  end

  assign rgb888 = rgb888_q;
`endif

  assign out_valid = out_valid_q;
  assign rgb565    = rgb565_q;

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Self-checking bench for hsv2rgb_pipe: constant vectors, corner sequences and a
// randomized stream scored against an arithmetic HSV->RGB reference model.
module tb_hsv2rgb_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  h = '0, s = '0, v = '0;
  logic        out_valid;
  logic [15:0] rgb565;
`ifdef HSV2RGB_RGB888_EN
  logic [23:0] rgb888;
`endif

  hsv2rgb_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .h        (h),
    .s        (s),
    .v        (v),
    .out_valid(out_valid),
    .rgb565   (rgb565)
`ifdef HSV2RGB_RGB888_EN
    ,
    .rgb888   (rgb888)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int div255(input int x);
    return (x + (x >> 8) + 1) >> 8;
  endfunction

  // Reference: hue wrapped mod 180, sector/offset by division, then the HSV formulas.
  function automatic logic [23:0] model(input logic [7:0] hh, input logic [7:0] ss, input logic [7:0] vv);
    int hw, sec, f, kq, p, q, t, r, g, b;
    hw  = int'(hh) % 180;
    sec = hw / 30;
    f   = hw % 30;
    kq  = (int'(ss) * f * 273) >> 13;
    p   = div255(int'(vv) * (255 - int'(ss)));
    q   = div255(int'(vv) * (255 - kq));
    t   = div255(int'(vv) * (255 - int'(ss) + kq));
    case (sec)
      0:       begin r = vv; g = t;  b = p;  end
      1:       begin r = q;  g = vv; b = p;  end
      2:       begin r = p;  g = vv; b = t;  end
      3:       begin r = p;  g = q;  b = vv; end
      4:       begin r = t;  g = p;  b = vv; end
      default: begin r = vv; g = p;  b = q;  end
    endcase
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic logic [15:0] to565(input logic [23:0] c);
    logic [7:0] r, g, b;
    {r, g, b} = c;
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  // Scoreboard: every accepted cycle enters a queue; its result is due four edges later.
  logic [24:0] pend[$];
  logic [23:0] held = '0;

  always @(posedge clk) begin
    logic [24:0] e;
    logic        exp_valid;
    exp_valid = 1'b0;
    if (rst) begin
      pend.delete();
      held = '0;
    end else begin
      pend.push_back({in_valid, model(h, s, v)});
    end
    #1;
    if (pend.size() >= 4) begin
      e = pend.pop_front();
      exp_valid = e[24];
      if (e[24]) held = e[23:0];
    end
    check("mon_out_valid", 24'(out_valid), 24'(exp_valid));
    check("mon_rgb565", 24'(rgb565), 24'(to565(held)));
`ifdef HSV2RGB_RGB888_EN
    check("mon_rgb888", rgb888, held);
`endif
  end

  task automatic drive(input logic vld, input logic [7:0] hh, input logic [7:0] ss, input logic [7:0] vv);
    in_valid = vld; h = hh; s = ss; v = vv;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  hh, ss, vv;
    logic [15:0] exp565;
    logic [23:0] exp888;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [4:0]  pat;
    logic [23:0] last;
    vecs[0] = '{8'd0,   8'd255, 8'd255, 16'hF800, 24'hFF0000};
    vecs[1] = '{8'd60,  8'd255, 8'd255, 16'h07E0, 24'h00FF00};
    vecs[2] = '{8'd120, 8'd255, 8'd255, 16'h001F, 24'h0000FF};
    vecs[3] = '{8'd15,  8'd255, 8'd255, 16'hFBE0, 24'hFF7F00};
    vecs[4] = '{8'd20,  8'd255, 8'd255, 16'hFD40, 24'hFFA900};
    vecs[5] = '{8'd200, 8'd255, 8'd255, 16'hFD40, 24'hFFA900};

    #2 rst = 1'b1;
    #1;
    check("reset_out_valid", 24'(out_valid), 24'd0);
    check("reset_rgb565", 24'(rgb565), 24'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Constant vectors, one isolated beat each.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].hh, vecs[i].ss, vecs[i].vv);
      repeat (3) drive(1'b0, 8'd0, 8'd0, 8'd0);
      check($sformatf("vec%0d_valid", i), 24'(out_valid), 24'd1);
      check($sformatf("vec%0d_rgb565", i), 24'(rgb565), 24'(vecs[i].exp565));
`ifdef HSV2RGB_RGB888_EN
      check($sformatf("vec%0d_rgb888", i), rgb888, vecs[i].exp888);
`endif
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      check($sformatf("vec%0d_gap_valid", i), 24'(out_valid), 24'd0);
      check($sformatf("vec%0d_hold", i), 24'(rgb565), 24'(vecs[i].exp565));
    end

    // Zero saturation: grey for every hue, streamed back-to-back.
    for (int k = 0; k < 183; k++) begin
      drive(k < 180, 8'(k), 8'd0, 8'd128);
      if (k >= 3) begin
        check($sformatf("grey_valid_%0d", k - 3), 24'(out_valid), 24'd1);
        check($sformatf("grey_rgb565_%0d", k - 3), 24'(rgb565), 24'h008410);
      end
    end

    // Sixteen continuous beats yield sixteen continuous outputs.
    for (int k = 0; k < 19; k++) begin
      drive(k < 16, 8'((k * 13 + 190) % 256), 8'($urandom), 8'($urandom));
      if (k >= 3) check($sformatf("burst_valid_%0d", k - 3), 24'(out_valid), 24'd1);
    end
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("burst_end_valid", 24'(out_valid), 24'd0);

    // Reset with samples in flight.
    for (int k = 0; k < 3; k++) drive(1'b1, 8'(40 * k), 8'd200, 8'd220);
    repeat (2) drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("pre_rst_valid", 24'(out_valid), 24'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 24'(out_valid), 24'd0);
    check("rst_async_rgb565", 24'(rgb565), 24'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      check($sformatf("no_stale_%0d", k), 24'(out_valid), 24'd0);
    end
    drive(1'b1, 8'd100, 8'd180, 8'd90);
    repeat (3) drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("post_rst_valid", 24'(out_valid), 24'd1);
    check("post_rst_rgb565", 24'(rgb565), 24'(to565(model(8'd100, 8'd180, 8'd90))));
    drive(1'b0, 8'd0, 8'd0, 8'd0);

    // Valid pattern 1,0,1,1,0 reappears four edges later; data holds through gaps.
    pat = 5'b01101;
    last = model(8'd100, 8'd180, 8'd90);
    for (int k = 0; k < 9; k++) begin
      logic ev;
      if (k < 5) drive(pat[k], 8'(k * 35), 8'd230, 8'd200);
      else       drive(1'b0, 8'd0, 8'd0, 8'd0);
      ev = (k >= 3 && k < 8) ? pat[k - 3] : 1'b0;
      if (ev) last = model(8'(35 * (k - 3)), 8'd230, 8'd200);
      check($sformatf("pattern_valid_%0d", k), 24'(out_valid), 24'(ev));
      check($sformatf("pattern_rgb565_%0d", k), 24'(rgb565), 24'(to565(last)));
    end

    // Randomized stream, scored by the monitor.
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 99) < 70, 8'($urandom), 8'($urandom), 8'($urandom));
    repeat (6) drive(1'b0, 8'd0, 8'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
